// File: rtl/dram_cmd_gen.sv
// rtl/dram_cmd_gen.sv - closed-page DRAM command sequencer: ACT, RD/WR, PRE per request with tRCD/tCL/tCWL/tRAS/tWR/tRP spacing
module dram_cmd_gen #(
    parameter int T_RCD   = 39,
    parameter int T_CL    = 40,
    parameter int T_CWL   = 38,
    parameter int T_BURST = 8,
    parameter int T_RAS   = 76,
    parameter int T_WR    = 72,
    parameter int T_RP    = 39
) (
    input  logic        dimm_clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_row,
    input  logic [2:0]  req_bg,
    input  logic [1:0]  req_bank,
    input  logic [9:0]  req_col,
    output logic        cmd_valid,
    output logic [1:0]  cmd_code,
    output logic [2:0]  cmd_bg,
    output logic [1:0]  cmd_bank,
    output logic [15:0] cmd_row,
    output logic [9:0]  cmd_col,
    output logic        data_done,
    output logic        op_err
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ACT       = 3'd1;
    localparam logic [2:0] WAIT_RCD  = 3'd2;
    localparam logic [2:0] COL       = 3'd3;
    localparam logic [2:0] WAIT_DATA = 3'd4;
    localparam logic [2:0] WAIT_PRE  = 3'd5;
    localparam logic [2:0] PRE       = 3'd6;
    localparam logic [2:0] WAIT_RP   = 3'd7;

    localparam logic [1:0] CMD_ACT = 2'd0;
    localparam logic [1:0] CMD_RD  = 2'd1;
    localparam logic [1:0] CMD_WR  = 2'd2;
    localparam logic [1:0] CMD_PRE = 2'd3;

    // Down-counter loads: each wait state runs load+1 cycles before its exit cycle.
    localparam logic [15:0] RCD_LOAD     = 16'(T_RCD - 2);
    localparam logic [15:0] RD_DATA_LOAD = 16'(T_CL + T_BURST - 2);
    localparam logic [15:0] WR_DATA_LOAD = 16'(T_CWL + T_BURST - 2);
    localparam logic [15:0] WR_REC_LOAD  = 16'(T_WR - 1);
    localparam logic [15:0] RP_LOAD      = 16'(T_RP - 2);
    localparam logic [16:0] RAS_LIM      = 17'(T_RAS);

    logic [2:0]  state, state_n;
    logic [15:0] wait_cnt, wait_n;
    logic [15:0] ras_cnt;
    logic [1:0]  op_q;
    logic [15:0] row_q;
    logic [2:0]  bg_q;
    logic [1:0]  bank_q;
    logic [9:0]  col_q;
    logic        accept, is_write, ras_ok;

    assign accept   = req_valid && req_ready && (state == IDLE);
    assign is_write = (op_q == 2'd1);
    // True when the next cycle is at least T_RAS after the ACT cycle.
    assign ras_ok   = ({1'b0, ras_cnt} + 17'd1) >= RAS_LIM;

    always_comb begin
        state_n = state;
        wait_n  = wait_cnt;
        case (state)
            IDLE: begin
                if (accept && req_op != 2'd3) state_n = ACT;
            end
            ACT: begin
                if (T_RCD == 1) begin
                    state_n = COL;
                end else begin
                    state_n = WAIT_RCD;
                    wait_n  = RCD_LOAD;
                end
            end
            WAIT_RCD: begin
                if (wait_cnt == 16'd0) state_n = COL;
                else wait_n = wait_cnt - 16'd1;
            end
            COL: begin
                state_n = WAIT_DATA;
                wait_n  = is_write ? WR_DATA_LOAD : RD_DATA_LOAD;
            end
            WAIT_DATA: begin
                if (wait_cnt == 16'd0) begin
                    if (!is_write && ras_ok) begin
                        state_n = PRE;
                    end else begin
                        state_n = WAIT_PRE;
                        wait_n  = is_write ? WR_REC_LOAD : 16'd0;
                    end
                end else begin
                    wait_n = wait_cnt - 16'd1;
                end
            end
            WAIT_PRE: begin
                if (wait_cnt == 16'd0) begin
                    if (ras_ok) state_n = PRE;
                end else begin
                    wait_n = wait_cnt - 16'd1;
                end
            end
            PRE: begin
                if (T_RP == 1) begin
                    state_n = IDLE;
                end else begin
                    state_n = WAIT_RP;
                    wait_n  = RP_LOAD;
                end
            end
            WAIT_RP: begin
                if (wait_cnt == 16'd0) state_n = IDLE;
                else wait_n = wait_cnt - 16'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge dimm_clock) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 16'd0;
            ras_cnt   <= 16'd0;
            req_ready <= 1'b0;
            op_err    <= 1'b0;
            op_q      <= 2'd0;
            row_q     <= 16'd0;
            bg_q      <= 3'd0;
            bank_q    <= 2'd0;
            col_q     <= 10'd0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_n;
            req_ready <= (state_n == IDLE);
            op_err    <= accept && (req_op == 2'd3);
            if (state_n == ACT && state == IDLE) ras_cnt <= 16'd0;
            else if (ras_cnt != 16'hFFFF) ras_cnt <= ras_cnt + 16'd1;
            if (accept) begin
                op_q   <= req_op;
                row_q  <= req_row;
                bg_q   <= req_bg;
                bank_q <= req_bank;
                col_q  <= req_col;
            end
        end
    end

    always_comb begin
        cmd_valid = 1'b0;
        cmd_code  = 2'd0;
        cmd_bg    = 3'd0;
        cmd_bank  = 2'd0;
        cmd_row   = 16'd0;
        cmd_col   = 10'd0;
        case (state)
            ACT: begin
                cmd_valid = 1'b1;
                cmd_code  = CMD_ACT;
                cmd_bg    = bg_q;
                cmd_bank  = bank_q;
                cmd_row   = row_q;
            end
            COL: begin
                cmd_valid = 1'b1;
                cmd_code  = is_write ? CMD_WR : CMD_RD;
                cmd_bg    = bg_q;
                cmd_bank  = bank_q;
                cmd_col   = col_q;
            end
            PRE: begin
                cmd_valid = 1'b1;
                cmd_code  = CMD_PRE;
                cmd_bg    = bg_q;
                cmd_bank  = bank_q;
            end
            default: ;
        endcase
    end

    assign data_done = (state == WAIT_DATA) && (wait_cnt == 16'd0);

endmodule

// File: tb/tb_dram_cmd_gen.sv
// tb/tb_dram_cmd_gen.sv - directed bench for dram_cmd_gen with default and short-CL instances
module tb_dram_cmd_gen;

    logic        dimm_clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [15:0] req_row = 16'd0;
    logic [2:0]  req_bg = 3'd0;
    logic [1:0]  req_bank = 2'd0;
    logic [9:0]  req_col = 10'd0;

    logic        req_ready, cmd_valid, data_done, op_err;
    logic [1:0]  cmd_code;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;

    logic        req_ready_f, cmd_valid_f, data_done_f, op_err_f;
    logic [1:0]  cmd_code_f;
    logic [2:0]  cmd_bg_f;
    logic [1:0]  cmd_bank_f;
    logic [15:0] cmd_row_f;
    logic [9:0]  cmd_col_f;

    dram_cmd_gen dut (
        .dimm_clock(dimm_clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_row(req_row), .req_bg(req_bg), .req_bank(req_bank), .req_col(req_col),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .data_done(data_done), .op_err(op_err)
    );

    dram_cmd_gen #(.T_CL(4), .T_BURST(4)) dut_f (
        .dimm_clock(dimm_clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_f), .req_op(req_op),
        .req_row(req_row), .req_bg(req_bg), .req_bank(req_bank), .req_col(req_col),
        .cmd_valid(cmd_valid_f), .cmd_code(cmd_code_f), .cmd_bg(cmd_bg_f), .cmd_bank(cmd_bank_f),
        .cmd_row(cmd_row_f), .cmd_col(cmd_col_f), .data_done(data_done_f), .op_err(op_err_f)
    );

    always #5 dimm_clock = ~dimm_clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Per-run observations, cycle numbers relative to the accept edge (cycle 0).
    int act_c, col_c, dd_c, pre_c, rdy_c, err_c;
    int ncmd, ndd, nerr, bad_idle, rdy_low, rst_nz;
    int act_row, act_bg, act_bank, col_code, col_col, col_bg, col_bank, pre_bg, pre_bank;
    int col_cf, dd_cf, pre_cf;

    task automatic run(input logic [1:0] op, input logic [15:0] row, input logic [2:0] bg,
                       input logic [1:0] bank, input logic [9:0] col, input int ncyc,
                       input bit scramble, input int rst_at);
        int w;
        w = 0;
        @(negedge dimm_clock);
        while (!req_ready && w < 300) begin
            @(negedge dimm_clock);
            w++;
        end
        check("ready_before_request", req_ready, 1);
        req_op = op; req_row = row; req_bg = bg; req_bank = bank; req_col = col;
        req_valid = 1'b1;
        act_c = -1; col_c = -1; dd_c = -1; pre_c = -1; rdy_c = -1; err_c = -1;
        ncmd = 0; ndd = 0; nerr = 0; bad_idle = 0; rdy_low = 0; rst_nz = 0;
        col_cf = -1; dd_cf = -1; pre_cf = -1;
        @(posedge dimm_clock);
        #1;
        if (!scramble) req_valid = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (scramble) begin
                if (c >= 39) req_valid = 1'b0;
                else begin
                    req_op = 2'($urandom_range(0, 3));
                    req_row = 16'($urandom);
                    req_bg = 3'($urandom);
                    req_bank = 2'($urandom);
                    req_col = 10'($urandom);
                end
            end
            if (cmd_valid) begin
                ncmd++;
                case (cmd_code)
                    2'd0: begin act_c = c; act_row = int'(cmd_row); act_bg = int'(cmd_bg); act_bank = int'(cmd_bank); end
                    2'd3: begin pre_c = c; pre_bg = int'(cmd_bg); pre_bank = int'(cmd_bank); end
                    default: begin
                        col_c = c; col_code = int'(cmd_code); col_col = int'(cmd_col);
                        col_bg = int'(cmd_bg); col_bank = int'(cmd_bank);
                    end
                endcase
            end else if (cmd_code != 0 || cmd_bg != 0 || cmd_bank != 0 || cmd_row != 0 || cmd_col != 0) begin
                bad_idle++;
            end
            if (data_done) begin ndd++; dd_c = c; end
            if (op_err) begin nerr++; err_c = c; end
            if (!req_ready) rdy_low++;
            else if (rdy_c < 0) rdy_c = c;
            if (cmd_valid_f && (cmd_code_f == 2'd1 || cmd_code_f == 2'd2) && col_cf < 0) col_cf = c;
            if (cmd_valid_f && cmd_code_f == 2'd3 && pre_cf < 0) pre_cf = c;
            if (data_done_f && dd_cf < 0) dd_cf = c;
            if (rst_at > 0 && (c == rst_at + 1 || c == rst_at + 2)) begin
                if (req_ready || cmd_valid || data_done || op_err || cmd_code != 0 || cmd_bg != 0 ||
                    cmd_bank != 0 || cmd_row != 0 || cmd_col != 0) rst_nz++;
            end
            if (rst_at > 0 && c == rst_at) reset = 1'b1;
            if (rst_at > 0 && c == rst_at + 2) reset = 1'b0;
            if (c < ncyc) begin
                @(posedge dimm_clock);
                #1;
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge dimm_clock);
        #1;
        check("reset_req_ready", req_ready, 0);
        check("reset_cmd_valid", cmd_valid, 0);
        check("reset_data_done", data_done, 0);
        check("reset_op_err", op_err, 0);
        @(negedge dimm_clock);
        reset = 1'b0;
        @(posedge dimm_clock);
        #1;
        check("ready_after_reset", req_ready, 1);

        run(2'd0, 16'h1234, 3'd5, 2'd2, 10'h03F, 130, 1'b0, 0);
        check("rd_act_cycle", act_c, 1);
        check("rd_act_row", act_row, 16'h1234);
        check("rd_act_bg", act_bg, 5);
        check("rd_act_bank", act_bank, 2);
        check("rd_col_cycle", col_c, 40);
        check("rd_col_code", col_code, 1);
        check("rd_col_col", col_col, 10'h03F);
        check("rd_col_bg", col_bg, 5);
        check("rd_col_bank", col_bank, 2);
        check("rd_done_cycle", dd_c, 87);
        check("rd_done_count", ndd, 1);
        check("rd_pre_cycle", pre_c, 88);
        check("rd_pre_bank", pre_bank, 2);
        check("rd_ready_cycle", rdy_c, 127);
        check("rd_ready_low", rdy_low, 126);
        check("rd_cmd_count", ncmd, 3);
        check("rd_idle_fields", bad_idle, 0);
        check("fast_col_cycle", col_cf, 40);
        check("fast_done_cycle", dd_cf, 47);
        check("fast_pre_cycle", pre_cf, 77);

        run(2'd1, 16'hBEEF, 3'd3, 2'd1, 10'h2A1, 200, 1'b0, 0);
        check("wr_act_cycle", act_c, 1);
        check("wr_act_row", act_row, 16'hBEEF);
        check("wr_col_cycle", col_c, 40);
        check("wr_col_code", col_code, 2);
        check("wr_col_col", col_col, 10'h2A1);
        check("wr_done_cycle", dd_c, 85);
        check("wr_pre_cycle", pre_c, 158);
        check("wr_pre_bg", pre_bg, 3);
        check("wr_ready_cycle", rdy_c, 197);
        check("wr_cmd_count", ncmd, 3);
        check("wr_idle_fields", bad_idle, 0);

        run(2'd2, 16'h0001, 3'd7, 2'd3, 10'h3FF, 130, 1'b0, 0);
        check("if_col_code", col_code, 1);
        check("if_col_col", col_col, 10'h3FF);
        check("if_done_cycle", dd_c, 87);
        check("if_ready_cycle", rdy_c, 127);

        run(2'd3, 16'hAAAA, 3'd2, 2'd0, 10'h100, 6, 1'b0, 0);
        check("ill_err_count", nerr, 1);
        check("ill_err_cycle", err_c, 1);
        check("ill_cmd_count", ncmd, 0);
        check("ill_ready_low", rdy_low, 0);

        run(2'd0, 16'h0F0F, 3'd1, 2'd3, 10'h155, 130, 1'b1, 0);
        check("hold_act_row", act_row, 16'h0F0F);
        check("hold_act_bg", act_bg, 1);
        check("hold_col_col", col_col, 10'h155);
        check("hold_col_bank", col_bank, 3);
        check("hold_col_code", col_code, 1);
        check("hold_cmd_count", ncmd, 3);
        check("hold_err_count", nerr, 0);
        check("hold_ready_cycle", rdy_c, 127);

        run(2'd0, 16'h4321, 3'd4, 2'd1, 10'h0AA, 150, 1'b0, 50);
        check("rst_pre_cycle", pre_c, -1);
        check("rst_outputs_zero", rst_nz, 0);
        check("rst_ready_cycle", rdy_c, 53);
        check("rst_cmd_count", ncmd, 2);
        check("rst_done_count", ndd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dram_cmd_gen.md
DRAM_CMD_GEN -- requirements
Module: dram_cmd_gen

Interface
REQ-001 SHALL provide parameter T_RCD, default 39: ACT-to-column-command spacing, in dimm_clock cycles.
REQ-002 SHALL provide parameter T_CL, default 40: RD-to-first-data spacing, in cycles.
REQ-003 SHALL provide parameter T_CWL, default 38: WR-to-first-data spacing, in cycles.
REQ-004 SHALL provide parameter T_BURST, default 8: data burst length, in cycles.
REQ-005 SHALL provide parameter T_RAS, default 76: minimum ACT-to-PRE spacing, in cycles.
REQ-006 SHALL provide parameter T_WR, default 72: write-recovery time from end of write data to PRE, in cycles.
REQ-007 SHALL provide parameter T_RP, default 39: PRE-to-next-ACT spacing, in cycles.
REQ-008 SHALL use one clock and a synchronous active-high reset; the ports are listed below, clock and reset first.
REQ-009 dimm_clock  in  1  sole clock; every flop updates on its rising edge.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 req_valid  in  1  decoded request present.
REQ-012 req_ready  out  1  block can accept a request.
REQ-013 req_op  in  2  request type: 0 = data read, 1 = data write, 2 = instruction fetch, 3 = illegal.
REQ-014 req_row  in  16  row address.
REQ-015 req_bg  in  3  bank group.
REQ-016 req_bank  in  2  bank.
REQ-017 req_col  in  10  column address.
REQ-018 cmd_valid  out  1  command issued this cycle.
REQ-019 cmd_code  out  2  command encoding: 0 = ACT, 1 = RD, 2 = WR, 3 = PRE.
REQ-020 cmd_bg, cmd_bank, cmd_row, cmd_col  out  3/2/16/10  command address fields.
REQ-021 data_done  out  1  one-cycle pulse on the last cycle of the data burst.
REQ-022 op_err  out  1  one-cycle pulse when an illegal op is accepted.

Function
REQ-023 SHALL complete a transfer when req_valid && req_ready are high on a rising edge, and SHALL register req_op, req_row, req_bg, req_bank and req_col at that edge.
REQ-024 SHALL drive req_ready high only in state IDLE; req_ready is a registered output.
REQ-025 SHALL implement states IDLE, ACT, WAIT_RCD, COL, WAIT_DATA, WAIT_PRE, PRE and WAIT_RP.
REQ-026 SHALL move from IDLE to ACT on accept, or to ERR_PULSE-free IDLE with op_err=1 in the next cycle when req_op=3; no command is issued for an illegal op, and req_ready stays high.
REQ-027 SHALL issue ACT with the latched bg/bank/row in the cycle after accept (cycle A).
REQ-028 SHALL issue the column command in cycle C = A+T_RCD: RD for op 0 or 2, WR for op 1, with the latched bg/bank/col.
REQ-029 SHALL pulse data_done in cycle D = C+T_CL+T_BURST-1 for reads and D = C+T_CWL+T_BURST-1 for writes.
REQ-030 SHALL issue PRE in cycle P = max(A+T_RAS, D+1) for reads and P = max(A+T_RAS, D+1+T_WR) for writes.
REQ-031 SHALL return to IDLE with req_ready=1 in cycle P+T_RP.
REQ-032 SHALL keep cmd_valid=1 for exactly one cycle per command; in every other cycle cmd_valid=0 and all cmd_* fields hold 0.
REQ-033 SHALL use a 16-bit down-counter for phase waits and a separate 16-bit up-counter for T_RAS measured from A; neither counter wraps, as all parameters are 1..65535.
REQ-034 SHALL ignore req_valid and all request fields whenever req_ready=0.
REQ-035 SHALL not issue back-to-back overlapping requests; the policy is closed-page, one request in flight.

Reset
REQ-036 SHALL, while reset=1, force state IDLE, clear both counters, drive req_ready=0, cmd_valid=0, cmd_*=0, data_done=0 and op_err=0.
REQ-037 SHALL drive req_ready=1 in the first cycle after reset deasserts.
REQ-038 SHALL abandon any operation in flight on reset without issuing PRE.

Verification
REQ-039 Read (op 0, bg 5, bank 2, row 0x1234, col 0x3F) accepted at cycle 0 -> ACT at 1, RD at 40, data_done at 87, PRE at 88, req_ready=1 at 127.
REQ-040 Write (op 1) accepted at 0 -> ACT at 1, WR at 40, data_done at 85, PRE at 158, req_ready=1 at 197.
REQ-041 Run with T_CL=4 and T_BURST=4, read accepted at 0 -> RD at 40, data_done at 47, PRE at 77 (T_RAS-bound).
REQ-042 op 3 accepted -> op_err=1 for one cycle, cmd_valid stays 0, req_ready never drops.
REQ-043 req_valid held high with changing fields during WAIT_RCD -> no new accept; command fields match the originally latched request.
REQ-044 Reset pulsed at cycle 50 of a read -> no PRE issued, all outputs 0 during reset, req_ready=1 in the cycle after release.
